// File: rtl/serial_sum_collector_pkg.sv
// Shared types and sizing helpers for the serial sum collector.
// Imported by the collector top and its bit-capture register.
package serial_sum_collector_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam int WIDTH_DEF = 4;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_sum_collector_sipo.sv
// Indexed serial-in parallel-out capture register.
// The clear and the indexed write may act together, which starts a new word.
module sipo_shift_reg
  import serial_sum_collector_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CW-1:0]    idx,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = clr ? '0 : q;
    if (en) q_d[idx] = din;
  end

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= q_d;
  end

endmodule

// File: rtl/serial_sum_collector.sv
// Assembles the LSB-first serial sum into a parallel word plus carry,
// with a single-entry valid/ready holding register and sticky error flags.
module serial_sum_collector
  import serial_sum_collector_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             sum_bit,
  input  logic             carry_bit,
  input  logic             sof,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             framing_err,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sr_clr, sr_en;
  logic [CW-1:0]    sr_idx;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] word;
  logic             done, ferr_set, free;

  sipo_shift_reg #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_sipo (
    .clk  (clk),
    .rst  (rst),
    .clr  (sr_clr),
    .en   (sr_en),
    .idx  (sr_idx),
    .din  (sum_bit),
    .q    (sr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_clr   = 1'b0;
    sr_en    = 1'b0;
    done     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bit_valid && sof) begin
          sr_clr  = 1'b1;
          sr_en   = 1'b1;
          cnt_d   = CW'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (bit_valid) begin
          if (sof) begin
            sr_clr   = 1'b1;
            sr_en    = 1'b1;
            cnt_d    = CW'(1);
            ferr_set = 1'b1;
          end else if (cnt_q == LAST) begin
            done    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            sr_en = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign sr_idx = sr_clr ? '0 : cnt_q;

  // The last bit bypasses the register so the word loads in its own cycle.
  always_comb begin
    word            = sr_q;
    word[WIDTH-1]   = sum_bit;
  end

  assign free = !out_valid || out_ready;
  assign busy = (state_q == COLLECT);

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_out     <= '0;
      cout        <= 1'b0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (done && free) begin
        sum_out   <= word;
        cout      <= carry_bit;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (done && !free) overrun <= 1'b1;
      if (ferr_set) framing_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_sum_collector.sv
// Directed bench for serial_sum_collector with a queue-based reference model.
module tb_serial_sum_collector;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         bit_valid, sum_bit, carry_bit, sof;
  logic [W-1:0] sum_out;
  logic         cout, out_valid, out_ready;
  logic         overrun, framing_err, busy;

  int tests = 0;
  int fails = 0;

  bit           q[$];
  logic [W-1:0] m_sum;
  logic         m_cout, m_valid, m_ovr, m_ferr;

  always #5 clk = ~clk;

  serial_sum_collector #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bit_valid   (bit_valid),
    .sum_bit     (sum_bit),
    .carry_bit   (carry_bit),
    .sof         (sof),
    .sum_out     (sum_out),
    .cout        (cout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .framing_err (framing_err),
    .busy        (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic         done;
    logic [W-1:0] w;
    done = 1'b0;
    w    = '0;
    if (rst) begin
      q.delete();
      m_sum = '0; m_cout = 0; m_valid = 0; m_ovr = 0; m_ferr = 0;
      return;
    end
    if (bit_valid) begin
      if (sof) begin
        if (q.size() > 0) m_ferr = 1'b1;
        q.delete();
        q.push_back(sum_bit);
      end else if (q.size() > 0) begin
        q.push_back(sum_bit);
        if (q.size() == W) begin
          done = 1'b1;
          for (int k = 0; k < W; k++) w[k] = q[k];
          q.delete();
        end
      end
    end
    if (done) begin
      if (!m_valid || out_ready) begin
        m_sum = w; m_cout = carry_bit; m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cyc(input logic bv, input logic sb,
                     input logic cb, input logic sf);
    bit_valid = bv; sum_bit = sb; carry_bit = cb; sof = sf;
    model_step();
    @(posedge clk);
    #1;
    chk("sum_out", sum_out, m_sum);
    chk("cout", cout, m_cout);
    chk("out_valid", out_valid, m_valid);
    chk("overrun", overrun, m_ovr);
    chk("framing_err", framing_err, m_ferr);
    chk("busy", busy, q.size() > 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic word(input logic [W-1:0] v, input logic c, input int gap);
    for (int i = 0; i < W; i++) begin
      cyc(1, v[i], (i == W - 1) ? c : 1'b0, i == 0);
      if (i < W - 1) idle(gap);
    end
  endtask

  initial begin
    rst = 1'b0; out_ready = 1'b0;
    bit_valid = 0; sum_bit = 0; carry_bit = 0; sof = 0;
    do_reset();
    chk("rst_sum", sum_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_flags", {overrun, framing_err, busy}, 0);

    // Stray bits without sof are ignored.
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);

    word(4'h8, 1'b0, 0);
    chk("t1_sum", sum_out, 8);
    chk("t1_valid", out_valid, 1);
    chk("t1_cout", cout, 0);
    out_ready = 1'b1; idle(1); out_ready = 1'b0;
    chk("t1_drain", out_valid, 0);

    word(4'h1, 1'b1, 2);
    chk("t2_sum", sum_out, 1);
    chk("t2_cout", cout, 1);
    out_ready = 1'b1; idle(1); out_ready = 1'b0;

    word(4'hA, 1'b0, 0);
    word(4'h3, 1'b1, 0);
    chk("t3_ovr", overrun, 1);
    chk("t3_held", sum_out, 10);
    chk("t3_cout", cout, 0);
    out_ready = 1'b1; idle(2); out_ready = 1'b0;
    do_reset();

    word(4'h5, 1'b0, 0);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    out_ready = 1'b1;
    cyc(1, 1, 1, 0);
    out_ready = 1'b0;
    chk("t4_valid", out_valid, 1);
    chk("t4_sum", sum_out, 12);
    chk("t4_ovr", overrun, 0);
    out_ready = 1'b1; idle(1); out_ready = 1'b0;

    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 0);
    word(4'h6, 1'b0, 0);
    chk("t5_ferr", framing_err, 1);
    chk("t5_sum", sum_out, 6);
    out_ready = 1'b1; idle(1); out_ready = 1'b0;

    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    do_reset();
    word(4'h6, 1'b0, 1);
    chk("t6_sum", sum_out, 6);
    chk("t6_flags", {overrun, framing_err}, 0);

    // Back-to-back words with the consumer always ready.
    out_ready = 1'b1;
    word(4'h9, 1'b1, 0);
    word(4'hF, 1'b0, 0);
    word(4'h2, 1'b1, 0);
    chk("t7_sum", sum_out, 2);
    chk("t7_ovr", overrun, 0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
